// File: rtl/ex_fwd_hazard_ctrl_pkg.sv
// rtl/ex_fwd_hazard_ctrl_pkg.sv - shared widths, forwarding select codes and shadow-stage records
package ex_fwd_hazard_ctrl_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [1:0] FW_REG = 2'b00;
  localparam logic [1:0] FW_WB  = 2'b01;
  localparam logic [1:0] FW_MEM = 2'b10;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      usesB;
    reg_addr_t rd;
    logic      regwr;
    logic      load;
  } stage_info_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      regwr;
    logic      load;
  } mem_info_t;

  // Once in WB a load's data is on Di like any other result, so the load flag is dropped
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      regwr;
  } wb_info_t;

endpackage

// File: rtl/ex_fwd_hazard_ctrl_if.sv
// rtl/ex_fwd_hazard_ctrl_if.sv - ID-stage inputs and EX forwarding/stall outputs of the hazard unit
interface ex_fwd_hazard_ctrl_if;
  import ex_fwd_hazard_ctrl_pkg::*;

  reg_addr_t  rs_ID;
  reg_addr_t  rt_ID;
  reg_addr_t  rd_ID;
  logic       regwr_ID;
  logic       load_ID;
  logic       usesB_ID;
  logic       flush_ID;
  logic       hold_ext;
  logic [1:0] BusAFW;
  logic [1:0] BusBFW;
  logic       stall_IF_ID;
  logic       bubble_EX;

  modport master (
    output rs_ID, rt_ID, rd_ID, regwr_ID, load_ID, usesB_ID, flush_ID, hold_ext,
    input  BusAFW, BusBFW, stall_IF_ID, bubble_EX
  );

  modport slave (
    input  rs_ID, rt_ID, rd_ID, regwr_ID, load_ID, usesB_ID, flush_ID, hold_ext,
    output BusAFW, BusBFW, stall_IF_ID, bubble_EX
  );

endinterface

// File: rtl/ex_fwd_hazard_ctrl_fwd_sel.sv
// rtl/ex_fwd_hazard_ctrl_fwd_sel.sv - M/WB compare and priority for one EX operand
module ex_fwd_hazard_ctrl_fwd_sel
  import ex_fwd_hazard_ctrl_pkg::*;
(
  input  logic       en,
  input  reg_addr_t  src,
  input  logic       m_wr,
  input  reg_addr_t  m_rd,
  input  logic       wb_wr,
  input  reg_addr_t  wb_rd,
  output logic [1:0] sel
);

  // r0 is hard-wired zero, so a write to it must never shadow the register file
  always_comb begin
    sel = FW_REG;
    if (en && (src != '0)) begin
      if (m_wr && (m_rd == src)) begin
        sel = FW_MEM;
      end else if (wb_wr && (wb_rd == src)) begin
        sel = FW_WB;
      end
    end
  end

endmodule

// File: rtl/ex_fwd_hazard_ctrl.sv
// rtl/ex_fwd_hazard_ctrl.sv - EX/M/WB shadow pipeline driving forwarding selects and load-use stalls
module ex_fwd_hazard_ctrl
  import ex_fwd_hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ex_fwd_hazard_ctrl_if.slave bus
);

  stage_info_t ex_q;
  mem_info_t   m_q;
  wb_info_t    wb_q;
  logic        luse;
  logic        stall;

  // A load in M is not forwardable, so the consumer must wait until the load reaches WB
  assign luse = ex_q.valid & ex_q.load & ex_q.regwr & (ex_q.rd != '0)
              & ((ex_q.rd == bus.rs_ID) | (bus.usesB_ID & (ex_q.rd == bus.rt_ID)));

  assign stall           = luse & ~bus.flush_ID & ~bus.hold_ext;
  assign bus.stall_IF_ID = stall;
  assign bus.bubble_EX   = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      m_q  <= '0;
      wb_q <= '0;
    end else if (!bus.hold_ext) begin
      wb_q <= '{valid: m_q.valid, rd: m_q.rd, regwr: m_q.regwr};
      m_q  <= '{valid: ex_q.valid, rd: ex_q.rd, regwr: ex_q.regwr, load: ex_q.load};
      if (stall || bus.flush_ID) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{valid: 1'b1, rs: bus.rs_ID, rt: bus.rt_ID, usesB: bus.usesB_ID,
                  rd: bus.rd_ID, regwr: bus.regwr_ID, load: bus.load_ID};
      end
    end
  end

  ex_fwd_hazard_ctrl_fwd_sel u_sel_a (
    .en    (ex_q.valid),
    .src   (ex_q.rs),
    .m_wr  (m_q.valid & m_q.regwr & ~m_q.load),
    .m_rd  (m_q.rd),
    .wb_wr (wb_q.valid & wb_q.regwr),
    .wb_rd (wb_q.rd),
    .sel   (bus.BusAFW)
  );

  ex_fwd_hazard_ctrl_fwd_sel u_sel_b (
    .en    (ex_q.valid & ex_q.usesB),
    .src   (ex_q.rt),
    .m_wr  (m_q.valid & m_q.regwr & ~m_q.load),
    .m_rd  (m_q.rd),
    .wb_wr (wb_q.valid & wb_q.regwr),
    .wb_rd (wb_q.rd),
    .sel   (bus.BusBFW)
  );

endmodule
